usb_protocol_ctrl: RTL and testbench
====================================

// Module: usb_protocol_ctrl
// PURPOSE
//  Transaction-level controller for the USB device endpoint, sitting above the RX packet decoder and TX encoder.
//  Consumes decoded token/data packets, owns the shared 64-byte data buffer, tracks DATA0/DATA1 toggles,
//  schedules ACK/NAK/DATA replies on TX, and enforces turnaround timeouts. Status goes to the AHB slave.
// PARAMETERS
//  TIMEOUT_CYCLES  800  clk cycles allowed for host DATA after OUT, or for host ACK after device DATA
//  BUF_DEPTH       64   data buffer capacity in bytes; occupancy must never exceed it
// PORTS
//  clk               in   1  system clock, all logic on posedge
//  rst               in   1  synchronous, active-high reset
//  rx_packet         in   3  decoded PID (usb_pkg::pkt_t); valid only with rx_packet_valid
//  rx_packet_valid   in   1  1-cycle pulse at EOP of a complete packet
//  rx_error          in   1  1-cycle pulse: bad PID, EOP or CRC in current packet
//  rx_data_ready     in   1  RX is writing payload bytes into the buffer
//  buffer_occupancy  in   7  bytes currently in buffer, 0..BUF_DEPTH
//  tx_armed          in   1  AHB has loaded an IN payload and released it to USB
//  tx_done           in   1  1-cycle pulse: TX finished sending requested packet
//  tx_packet         out  3  packet type for TX; held stable while tx_start pending/in flight
//  tx_start          out  1  1-cycle request pulse to TX
//  buffer_owner      out  2  usb_pkg::owner_t: AHB / RX / TX
//  clear_buffer      out  1  1-cycle flush of the data buffer
//  rx_toggle_o       out  1  expected toggle for next OUT DATA
//  tx_toggle_o       out  1  toggle used for next IN DATA
//  out_done          out  1  1-cycle pulse: OUT payload accepted (ACKed)
//  in_done           out  1  1-cycle pulse: IN payload acknowledged by host
//  timeout_err       out  1  1-cycle pulse on turnaround timeout
//  busy              out  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset: state IDLE, toggles 0, buffer_owner AHB, tx_packet NONE, all pulses and busy 0. rst mid-transaction
//   aborts immediately; no tx_start or clear_buffer issued for the aborted transaction.
//  States: IDLE, OUT_WAIT, OUT_RX, SEND_HS, WAIT_HS, IN_SEND, IN_TX, IN_ACK_WAIT.
//  IDLE: rx_packet_valid&OUT -> OUT_WAIT (owner RX, timer cleared). rx_packet_valid&IN: tx_armed & occupancy!=0
//   -> IN_SEND (owner TX), else tx_packet=NAK -> SEND_HS. Other PIDs, or any packet with rx_error, ignored.
//  OUT_WAIT: rx_data_ready -> OUT_RX. Timer hits TIMEOUT_CYCLES -> timeout_err, clear_buffer, IDLE.
//  OUT_RX (also OUT_WAIT on zero-length DATA): on rx_packet_valid: rx_error -> clear_buffer, IDLE, no reply.
//   DATAx==rx_toggle -> ACK, toggle flips, out_done.
//   DATAx!=rx_toggle (retry) -> ACK, clear_buffer, toggle kept.
//   Non-DATA PID -> clear_buffer, IDLE. All ACK paths go via SEND_HS.
//  SEND_HS: tx_start for one cycle -> WAIT_HS; WAIT_HS: tx_done -> IDLE, owner AHB.
//  IN_SEND: tx_packet=DATA0/1 per tx_toggle, tx_start one cycle -> IN_TX; tx_done -> IN_ACK_WAIT, timer cleared.
//  IN_ACK_WAIT: ACK -> tx_toggle flips, in_done, clear_buffer, owner AHB, IDLE. NAK, other PID, rx_error or
//   timeout -> payload retained, toggle kept, owner AHB, IDLE (timeout also pulses timeout_err).
//  Simultaneous: rx_packet_valid beats timeout in the same cycle. tx_done in IN_TX is never lost.
//  tx_start issued only in SEND_HS/IN_SEND, at most once per entry.
//  Timer: saturating, width $clog2(TIMEOUT_CYCLES+1); counts only in OUT_WAIT/OUT_RX/IN_ACK_WAIT; cleared on entry.
//  Occupancy: compare unsigned 7-bit; OUT DATA completing with occupancy > BUF_DEPTH -> NAK instead of ACK, flush.
//  Pulse outputs registered: asserted the cycle after the triggering input.
// STRUCTURE
//  usb_pkg: pkt_t {NONE, OUT, IN, DATA0, DATA1, ACK, NAK}, owner_t {AHB, RX, TX}, state enum, BUF_DEPTH default.
//  Sub-module usb_timeout_ctr (clear, enable, timeout param -> expired flag).
//  Remainder: one registered FSM plus toggle/owner registers.
// TESTING
//  OUT, DATA0 (8 bytes, rx_toggle=0) -> tx_packet=ACK, one tx_start, out_done, rx_toggle_o=1, owner back to AHB.
//  Repeat OUT+DATA0 with rx_toggle=1 -> ACK sent, clear_buffer pulse, rx_toggle_o stays 1, no out_done.
//  IN, tx_armed=0 -> NAK sent. IN, tx_armed=1, occ=16 -> DATA0, ACK after tx_done -> in_done, tx_toggle_o=1.
//  IN, DATA sent, host silent 800 cycles -> timeout_err on cycle 801, tx_toggle unchanged, IDLE, busy=0.
//  OUT then DATA1 with rx_error -> no tx_start, clear_buffer, IDLE. Reset asserted in IN_TX -> all outputs reset values.
//  rx_packet_valid(ACK) coincident with timeout expiry in IN_ACK_WAIT -> in_done, no timeout_err.

Source files
------------

// File: rtl/usb_protocol_ctrl_pkg.sv
// Shared types for the USB endpoint transaction controller: packet IDs, buffer owners, FSM states.
package usb_protocol_ctrl_pkg;

  typedef enum logic [2:0] {
    PktNone,
    PktOut,
    PktIn,
    PktData0,
    PktData1,
    PktAck,
    PktNak
  } pkt_t;

  typedef enum logic [1:0] {
    OwnAhb,
    OwnRx,
    OwnTx
  } owner_t;

  typedef enum logic [2:0] {
    StIdle,
    StOutWait,
    StOutRx,
    StSendHs,
    StWaitHs,
    StInSend,
    StInTx,
    StInAckWait
  } state_t;

  localparam int unsigned BufDepthDefault = 64;
  localparam int unsigned TimeoutDefault  = 800;

  function automatic logic is_data(pkt_t p);
    return (p == PktData0) || (p == PktData1);
  endfunction

  function automatic pkt_t data_pid(logic toggle);
    return toggle ? PktData1 : PktData0;
  endfunction

endpackage

// File: rtl/usb_protocol_ctrl_if.sv
// Packet, buffer and status signals between the controller and its RX/TX/AHB neighbours.
interface usb_protocol_ctrl_if;
  import usb_protocol_ctrl_pkg::*;

  pkt_t       rx_packet;
  logic       rx_packet_valid;
  logic       rx_error;
  logic       rx_data_ready;
  logic [6:0] buffer_occupancy;
  logic       tx_armed;
  logic       tx_done;

  pkt_t       tx_packet;
  logic       tx_start;
  owner_t     buffer_owner;
  logic       clear_buffer;
  logic       rx_toggle_o;
  logic       tx_toggle_o;
  logic       out_done;
  logic       in_done;
  logic       timeout_err;
  logic       busy;

  // Environment side: RX decoder, TX encoder and AHB slave.
  modport master (
    output rx_packet, rx_packet_valid, rx_error, rx_data_ready, buffer_occupancy, tx_armed,
           tx_done,
    input  tx_packet, tx_start, buffer_owner, clear_buffer, rx_toggle_o, tx_toggle_o, out_done,
           in_done, timeout_err, busy
  );

  // Controller side.
  modport slave (
    input  rx_packet, rx_packet_valid, rx_error, rx_data_ready, buffer_occupancy, tx_armed,
           tx_done,
    output tx_packet, tx_start, buffer_owner, clear_buffer, rx_toggle_o, tx_toggle_o, out_done,
           in_done, timeout_err, busy
  );

endinterface

// File: rtl/usb_protocol_ctrl_timeout_ctr.sv
// Saturating turnaround timer; expired_o holds once the count reaches TimeoutCycles.
module usb_protocol_ctrl_timeout_ctr #(
  parameter int unsigned TimeoutCycles = 800
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned     CntW   = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CntMax);

endmodule

// File: rtl/usb_protocol_ctrl.sv
// USB endpoint transaction controller: sequences OUT/IN transactions, data toggles, buffer
// ownership and handshake replies, with turnaround timeouts.
module usb_protocol_ctrl
  import usb_protocol_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutDefault,
  parameter int unsigned BUF_DEPTH      = BufDepthDefault
) (
  input logic                clk,
  input logic                rst,
  usb_protocol_ctrl_if.slave bus
);

  state_t state_d, state_q;
  owner_t owner_d, owner_q;
  pkt_t   tx_packet_d, tx_packet_q;
  logic   rx_toggle_d, rx_toggle_q;
  logic   tx_toggle_d, tx_toggle_q;
  logic   tx_start_d, tx_start_q;
  logic   clear_buffer_d, clear_buffer_q;
  logic   out_done_d, out_done_q;
  logic   in_done_d, in_done_q;
  logic   timeout_err_d, timeout_err_q;

  logic   timer_clear, timer_en, timer_expired;
  logic   pkt_event, pkt_good, occ_over, occ_nonzero;

  assign occ_over    = 32'(bus.buffer_occupancy) > BUF_DEPTH;
  assign occ_nonzero = (bus.buffer_occupancy != '0);
  // A lone rx_error still terminates a transaction that is waiting on the host.
  assign pkt_event   = bus.rx_packet_valid | bus.rx_error;
  assign pkt_good    = bus.rx_packet_valid & ~bus.rx_error;

  usb_protocol_ctrl_timeout_ctr #(
    .TimeoutCycles(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (timer_clear),
    .enable_i (timer_en),
    .expired_o(timer_expired)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    tx_packet_d    = tx_packet_q;
    rx_toggle_d    = rx_toggle_q;
    tx_toggle_d    = tx_toggle_q;
    tx_start_d     = 1'b0;
    clear_buffer_d = 1'b0;
    out_done_d     = 1'b0;
    in_done_d      = 1'b0;
    timeout_err_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pkt_good && (bus.rx_packet == PktOut)) begin
          state_d = StOutWait;
          owner_d = OwnRx;
        end else if (pkt_good && (bus.rx_packet == PktIn)) begin
          tx_start_d = 1'b1;
          if (bus.tx_armed && occ_nonzero) begin
            state_d     = StInSend;
            owner_d     = OwnTx;
            tx_packet_d = data_pid(tx_toggle_q);
          end else begin
            state_d     = StSendHs;
            tx_packet_d = PktNak;
          end
        end
      end

      StOutWait, StOutRx: begin
        if (pkt_event) begin
          if (!pkt_good || !is_data(bus.rx_packet)) begin
            clear_buffer_d = 1'b1;
            state_d        = StIdle;
          end else if (occ_over) begin
            tx_packet_d    = PktNak;
            tx_start_d     = 1'b1;
            clear_buffer_d = 1'b1;
            state_d        = StSendHs;
          end else begin
            tx_packet_d = PktAck;
            tx_start_d  = 1'b1;
            state_d     = StSendHs;
            if ((bus.rx_packet == PktData1) == rx_toggle_q) begin
              rx_toggle_d = ~rx_toggle_q;
              out_done_d  = 1'b1;
            end else begin
              // Host retried a packet we already accepted: ACK again, drop the duplicate.
              clear_buffer_d = 1'b1;
            end
          end
        end else if ((state_q == StOutWait) && bus.rx_data_ready) begin
          state_d = StOutRx;
        end else if (timer_expired) begin
          timeout_err_d  = 1'b1;
          clear_buffer_d = 1'b1;
          state_d        = StIdle;
        end
      end

      StSendHs: begin
        state_d = StWaitHs;
      end

      StWaitHs: begin
        if (bus.tx_done) begin
          state_d = StIdle;
        end
      end

      StInSend: begin
        state_d = bus.tx_done ? StInAckWait : StInTx;
      end

      StInTx: begin
        if (bus.tx_done) begin
          state_d = StInAckWait;
        end
      end

      StInAckWait: begin
        // A packet arriving on the expiry cycle takes priority over the timeout.
        if (pkt_event) begin
          state_d = StIdle;
          if (pkt_good && (bus.rx_packet == PktAck)) begin
            tx_toggle_d    = ~tx_toggle_q;
            in_done_d      = 1'b1;
            clear_buffer_d = 1'b1;
          end
        end else if (timer_expired) begin
          timeout_err_d = 1'b1;
          state_d       = StIdle;
        end
      end
    endcase

    if ((state_d == StIdle) && (state_q != StIdle)) begin
      owner_d     = OwnAhb;
      tx_packet_d = PktNone;
    end
  end

  assign timer_en    = (state_q == StOutWait) || (state_q == StOutRx) || (state_q == StInAckWait);
  assign timer_clear = ((state_d == StOutWait) && (state_q != StOutWait)) ||
                       ((state_d == StInAckWait) && (state_q != StInAckWait));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      owner_q        <= OwnAhb;
      tx_packet_q    <= PktNone;
      rx_toggle_q    <= 1'b0;
      tx_toggle_q    <= 1'b0;
      tx_start_q     <= 1'b0;
      clear_buffer_q <= 1'b0;
      out_done_q     <= 1'b0;
      in_done_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      tx_packet_q    <= tx_packet_d;
      rx_toggle_q    <= rx_toggle_d;
      tx_toggle_q    <= tx_toggle_d;
      tx_start_q     <= tx_start_d;
      clear_buffer_q <= clear_buffer_d;
      out_done_q     <= out_done_d;
      in_done_q      <= in_done_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign bus.tx_packet    = tx_packet_q;
  assign bus.tx_start     = tx_start_q;
  assign bus.buffer_owner = owner_q;
  assign bus.clear_buffer = clear_buffer_q;
  assign bus.rx_toggle_o  = rx_toggle_q;
  assign bus.tx_toggle_o  = tx_toggle_q;
  assign bus.out_done     = out_done_q;
  assign bus.in_done      = in_done_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_usb_protocol_ctrl.sv
// Self-checking bench: transaction-level model pushes expected output events, a monitor pops them.
module tb_usb_protocol_ctrl;
  import usb_protocol_ctrl_pkg::*;

  localparam int unsigned Timeout = 800;
  localparam int unsigned Depth   = 64;

  typedef struct packed {
    logic st;
    pkt_t pkt;
    logic clr;
    logic od;
    logic id;
    logic tmo;
    logic rxt;
    logic txt;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  usb_protocol_ctrl_if bus ();

  usb_protocol_ctrl #(
    .TIMEOUT_CYCLES(Timeout),
    .BUF_DEPTH     (Depth)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  ev_t  exp_q[$];
  logic m_rx, m_tx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic st, input pkt_t p, input logic clr, input logic od,
                      input logic id, input logic tmo);
    ev_t e;
    e.st  = st;
    e.pkt = p;
    e.clr = clr;
    e.od  = od;
    e.id  = id;
    e.tmo = tmo;
    e.rxt = m_rx;
    e.txt = m_tx;
    exp_q.push_back(e);
  endtask

  task automatic pulse_pkt(input pkt_t p, input logic err);
    bus.rx_packet       = p;
    bus.rx_packet_valid = 1'b1;
    bus.rx_error        = err;
    tick();
    bus.rx_packet_valid = 1'b0;
    bus.rx_error        = 1'b0;
    bus.rx_packet       = PktNone;
  endtask

  task automatic pulse_done();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    while (!bus.tx_start && (n < 50)) begin
      tick();
      n++;
    end
    check(name, 32'(bus.tx_start), 32'd1);
  endtask

  task automatic serve_tx(input string name);
    wait_start(name);
    repeat ($urandom_range(1, 6)) tick();
    pulse_done();
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while (bus.busy && (n < bound)) begin
      tick();
      n++;
    end
    check(name, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_settled(input string name);
    check({name, "_owner"}, 32'(bus.buffer_owner), 32'(OwnAhb));
    check({name, "_rx_toggle"}, 32'(bus.rx_toggle_o), 32'(m_rx));
    check({name, "_tx_toggle"}, 32'(bus.tx_toggle_o), 32'(m_tx));
  endtask

  task automatic check_reset(input string name);
    check({name, "_tx_packet"}, 32'(bus.tx_packet), 32'(PktNone));
    check({name, "_tx_start"}, 32'(bus.tx_start), 32'd0);
    check({name, "_clear"}, 32'(bus.clear_buffer), 32'd0);
    check({name, "_out_done"}, 32'(bus.out_done), 32'd0);
    check({name, "_in_done"}, 32'(bus.in_done), 32'd0);
    check({name, "_timeout"}, 32'(bus.timeout_err), 32'd0);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check_settled(name);
  endtask

  // kind: 0 data packet, 1 data with rx_error, 2 non-data PID, 3 host silent
  task automatic do_out(input int occ, input int kind, input logic tog, input logic zlp);
    bus.buffer_occupancy = 7'(occ);
    pulse_pkt(PktOut, 1'b0);
    check("out_owner_rx", 32'(bus.buffer_owner), 32'(OwnRx));
    if (kind == 3) begin
      push(1'b0, PktNone, 1'b1, 1'b0, 1'b0, 1'b1);
      wait_idle("out_timeout_idle", 1000);
    end else begin
      if (!zlp) begin
        bus.rx_data_ready = 1'b1;
        repeat ($urandom_range(1, 6)) tick();
        bus.rx_data_ready = 1'b0;
      end else begin
        repeat ($urandom_range(0, 3)) tick();
      end
      if (kind == 1) begin
        push(1'b0, PktNone, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_pkt(tog ? PktData1 : PktData0, 1'b1);
      end else if (kind == 2) begin
        push(1'b0, PktNone, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_pkt(PktAck, 1'b0);
      end else begin
        if (occ > int'(Depth)) begin
          push(1'b1, PktNak, 1'b1, 1'b0, 1'b0, 1'b0);
        end else if (tog == m_rx) begin
          m_rx = ~m_rx;
          push(1'b1, PktAck, 1'b0, 1'b1, 1'b0, 1'b0);
        end else begin
          push(1'b1, PktAck, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        pulse_pkt(tog ? PktData1 : PktData0, 1'b0);
        serve_tx("out_reply_start");
      end
      wait_idle("out_idle", 50);
    end
    check_settled("out_end");
  endtask

  // reply: 0 ACK, 1 NAK, 2 other PID, 3 ACK with rx_error, 4 silent, 5 ACK on expiry cycle
  task automatic do_in(input logic armed, input int occ, input int reply);
    int n;
    bus.tx_armed         = armed;
    bus.buffer_occupancy = 7'(occ);
    if (armed && (occ != 0)) begin
      push(1'b1, m_tx ? PktData1 : PktData0, 1'b0, 1'b0, 1'b0, 1'b0);
      pulse_pkt(PktIn, 1'b0);
      check("in_owner_tx", 32'(bus.buffer_owner), 32'(OwnTx));
      serve_tx("in_data_start");
      case (reply)
        0: begin
          m_tx = ~m_tx;
          push(1'b0, PktNone, 1'b1, 1'b0, 1'b1, 1'b0);
          repeat ($urandom_range(0, 8)) tick();
          pulse_pkt(PktAck, 1'b0);
        end
        1: begin
          repeat ($urandom_range(0, 8)) tick();
          pulse_pkt(PktNak, 1'b0);
        end
        2: begin
          repeat ($urandom_range(0, 8)) tick();
          pulse_pkt(PktData0, 1'b0);
        end
        3: begin
          repeat ($urandom_range(0, 8)) tick();
          pulse_pkt(PktAck, 1'b1);
        end
        4: begin
          push(1'b0, PktNone, 1'b0, 1'b0, 1'b0, 1'b1);
          n = 0;
          do begin
            tick();
            n++;
          end while (!bus.timeout_err && (n < 900));
          check("in_timeout_latency", 32'(n), 32'(Timeout + 1));
          check("in_timeout_busy", 32'(bus.busy), 32'd0);
        end
        default: begin
          m_tx = ~m_tx;
          push(1'b0, PktNone, 1'b1, 1'b0, 1'b1, 1'b0);
          repeat (Timeout) tick();
          pulse_pkt(PktAck, 1'b0);
        end
      endcase
    end else begin
      push(1'b1, PktNak, 1'b0, 1'b0, 1'b0, 1'b0);
      pulse_pkt(PktIn, 1'b0);
      check("in_nak_owner", 32'(bus.buffer_owner), 32'(OwnAhb));
      serve_tx("in_nak_start");
    end
    wait_idle("in_idle", 1000);
    check_settled("in_end");
  endtask

  task automatic do_junk();
    if ($urandom_range(0, 1) == 0) begin
      pulse_pkt(pkt_t'(3'($urandom_range(0, 6))), 1'b1);
    end else begin
      case ($urandom_range(0, 4))
        0:       pulse_pkt(PktNone, 1'b0);
        1:       pulse_pkt(PktData0, 1'b0);
        2:       pulse_pkt(PktData1, 1'b0);
        3:       pulse_pkt(PktAck, 1'b0);
        default: pulse_pkt(PktNak, 1'b0);
      endcase
    end
    check("junk_ignored", 32'(bus.busy), 32'd0);
  endtask

  always @(negedge clk) begin
    ev_t act;
    ev_t e;
    if (!rst && (bus.tx_start || bus.clear_buffer || bus.out_done || bus.in_done ||
                 bus.timeout_err)) begin
      act.st  = bus.tx_start;
      act.pkt = bus.tx_start ? bus.tx_packet : PktNone;
      act.clr = bus.clear_buffer;
      act.od  = bus.out_done;
      act.id  = bus.in_done;
      act.tmo = bus.timeout_err;
      act.rxt = bus.rx_toggle_o;
      act.txt = bus.tx_toggle_o;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got %h expected none", act);
      end else begin
        e = exp_q.pop_front();
        if (act != e) begin
          n_fail++;
          $display("FAIL event: got %h expected %h", act, e);
        end
      end
    end
  end

  initial begin
    rst                  = 1'b1;
    bus.rx_packet        = PktNone;
    bus.rx_packet_valid  = 1'b0;
    bus.rx_error         = 1'b0;
    bus.rx_data_ready    = 1'b0;
    bus.buffer_occupancy = '0;
    bus.tx_armed         = 1'b0;
    bus.tx_done          = 1'b0;
    m_rx                 = 1'b0;
    m_tx                 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset("reset");

    do_out(8, 0, 1'b0, 1'b0);
    do_out(8, 0, 1'b0, 1'b0);
    do_in(1'b0, 16, 0);
    do_in(1'b1, 16, 0);
    do_in(1'b1, 16, 4);
    do_out(8, 1, 1'b1, 1'b0);
    do_in(1'b1, 16, 5);

    // Reset while the IN data packet is in flight.
    bus.tx_armed         = 1'b1;
    bus.buffer_occupancy = 7'd16;
    push(1'b1, m_tx ? PktData1 : PktData0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_pkt(PktIn, 1'b0);
    wait_start("rst_in_start");
    tick();
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    m_rx = 1'b0;
    m_tx = 1'b0;
    check_reset("reset_in_tx");
    repeat (5) tick();

    do_out(100, 0, m_rx, 1'b0);
    do_out(0, 0, m_rx, 1'b1);
    do_out(8, 3, 1'b0, 1'b0);
    do_out(8, 2, 1'b0, 1'b0);
    do_in(1'b1, 0, 0);
    repeat (3) do_junk();

    for (int i = 0; i < 150; i++) begin
      int r;
      int sub;
      int occ;
      r = int'($urandom_range(0, 99));
      if (r < 45) begin
        sub = int'($urandom_range(0, 99));
        occ = ($urandom_range(0, 9) == 0) ? int'($urandom_range(65, 127))
                                          : int'($urandom_range(0, 64));
        do_out(occ, (sub < 8) ? 1 : (sub < 14) ? 2 : (sub < 16) ? 3 : 0,
               1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
      end else if (r < 90) begin
        sub = int'($urandom_range(0, 99));
        occ = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 64));
        do_in($urandom_range(0, 4) != 0, occ,
              (sub < 55) ? 0 : (sub < 65) ? 1 : (sub < 73) ? 2 : (sub < 81) ? 3 :
              (sub < 83) ? 4 : (sub < 85) ? 5 : 0);
      end else begin
        do_junk();
      end
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (5) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
